cache_arbiter: RTL
==================

// Module: cache_arbiter
// PURPOSE
//  Shares the single cache port between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
//  Presents one access at a time to the cache as addr/rw/ce, waits for odv, returns read data and a 1-cycle ack.
//  Sits between the processor front end and the cache. Drives separate wdata/rdata buses; the cache-side inout is
//  resolved at top level. A watchdog aborts accesses the cache never completes.
// PARAMETERS
//  d_width   8   data bus width
//  a_width   8   address width
//  wd_limit  15  max cycles in BUSY waiting for odv before abort (4-bit watchdog counter)
// PORTS
//  clk       input   1        clock, all state on posedge
//  clr       input   1        synchronous active-high clear
//  req       input   2        req[i]=1: port i requests; held with addr/rw/wdata stable until ack[i]
//  addr0     input   a_width  port 0 address
//  addr1     input   a_width  port 1 address
//  rw1       input   1        port 1: 1=read, 0=write (port 0 is always read)
//  wdata1    input   d_width  port 1 write data
//  ack       output  2        ack[i] 1-cycle pulse: port i access complete
//  err       output  1        1-cycle pulse with ack: access aborted by watchdog
//  rdata     output  d_width  read data, valid in ack cycle, held until next ack
//  c_addr    output  a_width  address to cache
//  c_rw      output  1        rw to cache
//  c_wdata   output  d_width  write data to cache
//  c_ce      output  1        chip enable to cache
//  c_rdata   input   d_width  read data from cache
//  c_odv     input   1        cache output data valid
//  busy      output  1        1 when state != IDLE
// BEHAVIOUR
//  Clear (clr=1 at edge): state=IDLE; ack=0, err=0, rdata=0, c_addr=0, c_rw=1, c_wdata=0, c_ce=0, busy=0,
//   wd counter=0, last-grant=port 1. Clear mid-access abandons it: no ack, c_ce low next cycle.
//  FSM states IDLE, BUSY, ACK:
//   IDLE: if req!=0: pick winner, latch its addr/rw/wdata into c_addr/c_rw/c_wdata, c_ce<=1, gnt<=winner,
//    wd<=0 -> BUSY. Else stay; c_ce=0.
//   BUSY: c_ce held 1, cache inputs held stable. If c_odv=1: c_ce<=0, rdata<=c_rdata (also on write),
//    ack[gnt]<=1 -> ACK. Else wd<=wd+1; if wd==wd_limit-1: c_ce<=0, ack[gnt]<=1, err<=1,
//    rdata unchanged -> ACK.
//   ACK: ack<=0, err<=0, c_ce=0 -> IDLE. Mandatory 1-cycle ce-low gap so the cache does not repeat
//    the access and clears odv before the next issue.
//  c_odv ignored outside BUSY. req changes outside IDLE are not sampled; requester must drop req[i]
//   in the cycle after ack[i] or it is treated as a new request.
//  Latency: req sampled at edge N; c_ce high after N; cache hit -> odv after N+1; ack high after N+2.
//   Cache miss (8-cycle fill) -> ack after N+9. Min re-issue spacing: 3 cycles per access.
//  Port 0 write impossible: c_rw forced 1 when gnt=0.
//  Simultaneous req=2'b11: arbitration per CONFIGURATION; loser waits, is served at next IDLE.
//  ack and err are never high in the same cycle for different ports; ack is one-hot or zero.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin; on req=2'b11 grant the port != last-grant; last-grant updated on every
//   IDLE->BUSY.
//  ARB_RR_EN undefined: fixed priority, port 1 (data) wins on req=2'b11; last-grant register not built.
// TESTING
//  Single read: req=01, addr0=8'h10, cache hit with c_rdata=8'hA5 -> c_ce 1 cycle after req, ack=01 two
//   cycles later, rdata=8'hA5, err=0.
//  Write: req=10, rw1=0, addr1=8'h20, wdata1=8'h3C -> c_rw=0, c_addr=8'h20, c_wdata=8'h3C while c_ce=1,
//   ack=10 after odv.
//  Miss timing: odv delayed 8 cycles -> c_ce held 1, inputs stable throughout, ack=01 at N+9, c_ce low in
//   ACK cycle.
//  Contention: req=11 held for 4 accesses -> fixed: 10,10,10,10; ARB_RR_EN: 01,10,01,10 (after clear,
//   first grant=0).
//  Watchdog: odv never asserted -> after 15 BUSY cycles ack[gnt]=1 and err=1 together, rdata unchanged,
//   then IDLE.
//  Clear mid-BUSY: clr=1 during miss wait -> next cycle c_ce=0, busy=0, no ack; new req served normally.

Source files
------------

// File: rtl/cache_arbiter.sv
// ----------------------------------------------------------------------------
// cache_arbiter
//
// Shares a single cache port between two requesters: port 0 (instruction
// fetch, read-only) and port 1 (data load/store). One access at a time is
// presented to the cache on c_addr/c_rw/c_wdata with c_ce held high until the
// cache raises c_odv. The requester then gets a 1-cycle ack and the read data.
// A watchdog aborts an access the cache never completes and flags it with err.
// Every access ends with a mandatory c_ce-low cycle (ACK) before the next one.
//
// Optional feature macro: ARB_RR_EN
//   defined   : round-robin between the ports when both request together
//   undefined : fixed priority, port 1 (data) wins a tie
//
// Parameters
//   d_width   data bus width
//   a_width   address width
//   wd_limit  max BUSY cycles without c_odv before the access is aborted
//
// Ports
//   clk      clock, all state updates on the rising edge
//   clr      synchronous active-high clear
//   req      req[i]=1 : port i requests, held stable until ack[i]
//   addr0    port 0 address
//   addr1    port 1 address
//   rw1      port 1 direction, 1=read 0=write
//   wdata1   port 1 write data
//   ack      one-hot 1-cycle completion pulse per port
//   err      1-cycle pulse alongside ack when the watchdog aborted the access
//   rdata    read data, valid in the ack cycle, held until the next ack
//   c_addr   cache address
//   c_rw     cache direction, 1=read 0=write
//   c_wdata  cache write data
//   c_ce     cache chip enable
//   c_rdata  cache read data
//   c_odv    cache output data valid
//   busy     1 whenever an access is in flight (state != IDLE)
// ----------------------------------------------------------------------------
module cache_arbiter #(
    parameter int d_width  = 8,
    parameter int a_width  = 8,
    parameter int wd_limit = 15
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [1:0]         req,
    input  logic [a_width-1:0] addr0,
    input  logic [a_width-1:0] addr1,
    input  logic               rw1,
    input  logic [d_width-1:0] wdata1,
    output logic [1:0]         ack,
    output logic               err,
    output logic [d_width-1:0] rdata,
    output logic [a_width-1:0] c_addr,
    output logic               c_rw,
    output logic [d_width-1:0] c_wdata,
    output logic               c_ce,
    input  logic [d_width-1:0] c_rdata,
    input  logic               c_odv,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ACK
    } state_t;

    // Watchdog fires on the BUSY cycle where the counter has reached this value.
    localparam logic [3:0] WD_LAST = 4'(wd_limit - 1);

    state_t             state,     nxt_state;
    logic               gnt,       nxt_gnt;
    logic [3:0]         wd,        nxt_wd;
    logic [1:0]         nxt_ack;
    logic               nxt_err;
    logic [d_width-1:0] nxt_rdata;
    logic [a_width-1:0] nxt_c_addr;
    logic               nxt_c_rw;
    logic [d_width-1:0] nxt_c_wdata;
    logic               nxt_c_ce;
    logic               winner;

`ifdef ARB_RR_EN
    logic               last_gnt,  nxt_last_gnt;
`endif

    assign busy = (state != ST_IDLE);

    // Arbitration: on a tie the round-robin build grants the port that did not
    // win last time; the fixed build always favours the data port.
    always_comb begin
        winner = req[1];
`ifdef ARB_RR_EN
        if (req == 2'b11) begin
            winner = ~last_gnt;
        end
`endif
    end

    // Next-state and next-output logic. All cache-side outputs are registered
    // so the cache sees glitch-free, stable inputs for the whole access.
    always_comb begin
        nxt_state   = state;
        nxt_gnt     = gnt;
        nxt_wd      = wd;
        nxt_ack     = 2'b00;
        nxt_err     = 1'b0;
        nxt_rdata   = rdata;
        nxt_c_addr  = c_addr;
        nxt_c_rw    = c_rw;
        nxt_c_wdata = c_wdata;
        nxt_c_ce    = 1'b0;
`ifdef ARB_RR_EN
        nxt_last_gnt = last_gnt;
`endif

        case (state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    nxt_c_addr = winner ? addr1 : addr0;
                    // Port 0 is fetch-only, so it can never issue a write.
                    nxt_c_rw   = winner ? rw1 : 1'b1;
                    if (winner) begin
                        nxt_c_wdata = wdata1;
                    end
                    nxt_c_ce  = 1'b1;
                    nxt_gnt   = winner;
                    nxt_wd    = 4'd0;
                    nxt_state = ST_BUSY;
`ifdef ARB_RR_EN
                    nxt_last_gnt = winner;
`endif
                end
            end

            ST_BUSY: begin
                nxt_c_ce = 1'b1;
                if (c_odv) begin
                    // Capture c_rdata even on writes; the cache defines what it returns.
                    nxt_c_ce  = 1'b0;
                    nxt_rdata = c_rdata;
                    nxt_ack   = gnt ? 2'b10 : 2'b01;
                    nxt_state = ST_ACK;
                end else begin
                    nxt_wd = wd + 4'd1;
                    if (wd == WD_LAST) begin
                        nxt_c_ce  = 1'b0;
                        nxt_ack   = gnt ? 2'b10 : 2'b01;
                        nxt_err   = 1'b1;
                        nxt_state = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                // One cycle with c_ce low so the cache drops odv and does not
                // mistake a back-to-back issue for a continuation.
                nxt_state = ST_IDLE;
            end

            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= ST_IDLE;
            gnt     <= 1'b0;
            wd      <= 4'd0;
            ack     <= 2'b00;
            err     <= 1'b0;
            rdata   <= '0;
            c_addr  <= '0;
            c_rw    <= 1'b1;
            c_wdata <= '0;
            c_ce    <= 1'b0;
        end else begin
            state   <= nxt_state;
            gnt     <= nxt_gnt;
            wd      <= nxt_wd;
            ack     <= nxt_ack;
            err     <= nxt_err;
            rdata   <= nxt_rdata;
            c_addr  <= nxt_c_addr;
            c_rw    <= nxt_c_rw;
            c_wdata <= nxt_c_wdata;
            c_ce    <= nxt_c_ce;
        end
    end

`ifdef ARB_RR_EN
    // Last-grant history; clears to port 1 so the first tie goes to port 0.
    always_ff @(posedge clk) begin
        if (clr) begin
            last_gnt <= 1'b1;
        end else begin
            last_gnt <= nxt_last_gnt;
        end
    end
`endif

endmodule
